// File: rtl/sine_nco.sv
// ---------------------------------------------------------------------------
// sine_nco - numerically-controlled oscillator on a quarter-wave sine ROM.
//
// Phase accumulator plus per-sample phase offset, folded into one quadrant,
// looked up in a quarter-wave table and sign-restored to a two's complement
// sample. Three register stages; one sample per enabled cycle.
//
// Optional feature macro: SINE_NCO_COS_EN
//   Defined  -> adds dout_cos_o (quadrature output, phase + quarter turn)
//               through a second table read port.
//   Undefined -> no cosine port and no second read port.
//
// Ports
//   clk_i          in   1             rising-edge clock
//   rst_ni         in   1             asynchronous active-low reset
//   en_i           in   1             advance accumulator, launch one sample
//   phase_clr_i    in   1             synchronous accumulator clear
//   freq_word_i    in   PHASE_WIDTH   phase increment per enabled cycle
//   phase_off_i    in   PHASE_WIDTH   offset added to the sample phase only
//   dout_o         out  ROM_WIDTH+1   signed sine sample
//   dout_valid_o   out  1             dout_o carries a new sample
//   dout_cos_o     out  ROM_WIDTH+1   signed cosine sample (macro only)
//
// Parameters
//   ROM_WIDTH   magnitude bits per table entry
//   ROM_DEPTH   entries per quarter wave (power of 2, >= 4)
//   PHASE_WIDTH accumulator width (>= clog2(ROM_DEPTH)+2)
// ---------------------------------------------------------------------------
module sine_nco #(
  parameter int ROM_WIDTH   = 8,
  parameter int ROM_DEPTH   = 64,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   phase_clr_i,
  input  logic [PHASE_WIDTH-1:0] freq_word_i,
  input  logic [PHASE_WIDTH-1:0] phase_off_i,
  output logic [ROM_WIDTH:0]     dout_o,
  output logic                   dout_valid_o
`ifdef SINE_NCO_COS_EN
  ,
  output logic [ROM_WIDTH:0]     dout_cos_o
`endif
);

  localparam int ADDR_W = $clog2(ROM_DEPTH);
  localparam int IDX_W  = ADDR_W + 2;
  localparam real PI    = 3.14159265358979323846;

  // Entries are sampled at the centre of each step (k+0.5), so no entry is 0
  // and the table is symmetric about the quarter point without a duplicate.
  function automatic logic [ROM_WIDTH-1:0] rom_entry(input int k);
    real amp;
    real x;
    amp = real'((2 ** ROM_WIDTH) - 1);
    x   = amp * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(ROM_DEPTH));
    return ROM_WIDTH'($rtoi(x + 0.5));
  endfunction

  logic [ROM_WIDTH-1:0] rom [ROM_DEPTH];

  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    localparam logic [ROM_WIDTH-1:0] ENTRY = rom_entry(k);
    assign rom[k] = ENTRY;
  end

  // -------------------------------------------------------------------------
  // Phase accumulator
  // -------------------------------------------------------------------------
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] acc_base;
  logic [PHASE_WIDTH-1:0] phase;
  logic [IDX_W-1:0]       idx;

  // A clear coinciding with an enable launches the sample at phase 0.
  assign acc_base = phase_clr_i ? '0 : acc_q;
  assign phase    = acc_base + phase_off_i;
  assign idx      = phase[PHASE_WIDTH-1 -: IDX_W];

  always_comb begin
    acc_d = acc_q;
    if (phase_clr_i) begin
      acc_d = en_i ? freq_word_i : '0;
    end else if (en_i) begin
      acc_d = acc_q + freq_word_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // -------------------------------------------------------------------------
  // S1: quadrant, in-quadrant address, launch flag
  // -------------------------------------------------------------------------
  logic [1:0]        q1_q, q1_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic              v1_q;

  always_comb begin
    q1_d = q1_q;
    a1_d = a1_q;
    if (en_i) begin
      q1_d = idx[ADDR_W+1:ADDR_W];
      a1_d = idx[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q1_q <= '0;
      a1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      q1_q <= q1_d;
      a1_q <= a1_d;
      v1_q <= en_i;
    end
  end

  // -------------------------------------------------------------------------
  // S2: table read and sign flag
  // -------------------------------------------------------------------------
  // Odd quadrants run the table backwards; DEPTH-1-a equals ~a because the
  // depth is a power of two.
  logic [ADDR_W-1:0]    rd_addr;
  logic [ROM_WIDTH-1:0] mag2_q, mag2_d;
  logic                 neg2_q, neg2_d;
  logic                 v2_q;

  assign rd_addr = q1_q[0] ? ~a1_q : a1_q;

  always_comb begin
    mag2_d = mag2_q;
    neg2_d = neg2_q;
    if (v1_q) begin
      mag2_d = rom[rd_addr];
      neg2_d = q1_q[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mag2_q <= '0;
      neg2_q <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      mag2_q <= mag2_d;
      neg2_q <= neg2_d;
      v2_q   <= v1_q;
    end
  end

  // -------------------------------------------------------------------------
  // S3: sign restore; output holds between valid samples
  // -------------------------------------------------------------------------
  logic [ROM_WIDTH:0] ext2;
  logic [ROM_WIDTH:0] res2;
  logic [ROM_WIDTH:0] dout_q, dout_d;
  logic               vld_q;

  // Magnitude never exceeds 2^ROM_WIDTH-1, so negating in ROM_WIDTH+1 bits
  // cannot overflow.
  assign ext2 = {1'b0, mag2_q};
  assign res2 = neg2_q ? -ext2 : ext2;

  always_comb begin
    dout_d = dout_q;
    if (v2_q) begin
      dout_d = res2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= v2_q;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = vld_q;

`ifdef SINE_NCO_COS_EN
  // -------------------------------------------------------------------------
  // Cosine path: a quarter turn only touches the two quadrant bits, so the
  // cosine quadrant is q+1 with the same in-quadrant address.
  // -------------------------------------------------------------------------
  logic [1:0]           qc1_q, qc1_d;
  logic [ADDR_W-1:0]    rd_addr_c;
  logic [ROM_WIDTH-1:0] magc2_q, magc2_d;
  logic                 negc2_q, negc2_d;
  logic [ROM_WIDTH:0]   extc2;
  logic [ROM_WIDTH:0]   resc2;
  logic [ROM_WIDTH:0]   doutc_q, doutc_d;

  always_comb begin
    qc1_d = qc1_q;
    if (en_i) begin
      qc1_d = idx[ADDR_W+1:ADDR_W] + 2'd1;
    end
  end

  assign rd_addr_c = qc1_q[0] ? ~a1_q : a1_q;

  always_comb begin
    magc2_d = magc2_q;
    negc2_d = negc2_q;
    if (v1_q) begin
      magc2_d = rom[rd_addr_c];
      negc2_d = qc1_q[1];
    end
  end

  assign extc2 = {1'b0, magc2_q};
  assign resc2 = negc2_q ? -extc2 : extc2;

  always_comb begin
    doutc_d = doutc_q;
    if (v2_q) begin
      doutc_d = resc2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qc1_q   <= '0;
      magc2_q <= '0;
      negc2_q <= 1'b0;
      doutc_q <= '0;
    end else begin
      qc1_q   <= qc1_d;
      magc2_q <= magc2_d;
      negc2_q <= negc2_d;
      doutc_q <= doutc_d;
    end
  end

  assign dout_cos_o = doutc_q;
`endif

endmodule

// File: tb/tb_sine_nco.sv
// ---------------------------------------------------------------------------
// tb_sine_nco - directed bench for sine_nco (ROM_WIDTH=8, ROM_DEPTH=64,
// PHASE_WIDTH=16). Each cycle the outputs are compared against a reference
// sample model; key points are also checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sine_nco;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        phase_clr_i;
  logic [15:0] freq_word_i;
  logic [15:0] phase_off_i;
  logic [8:0]  dout_o;
  logic        dout_valid_o;
`ifdef SINE_NCO_COS_EN
  logic [8:0]  dout_cos_o;
`endif

  sine_nco #(
    .ROM_WIDTH   (8),
    .ROM_DEPTH   (64),
    .PHASE_WIDTH (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .phase_clr_i  (phase_clr_i),
    .freq_word_i  (freq_word_i),
    .phase_off_i  (phase_off_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o)
`ifdef SINE_NCO_COS_EN
    ,
    .dout_cos_o   (dout_cos_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int tbl [64];

  // reference pipeline: [0]=launch stage, [1]=table stage, out=registered output
  logic [15:0] m_acc;
  logic        mv [3];
  logic [8:0]  md [2];
  logic [8:0]  mc [2];
  logic [8:0]  m_out;
  logic [8:0]  mc_out;

  function automatic logic [8:0] ref_val(input logic [15:0] p);
    logic [7:0] idx;
    int mag;
    idx = p[15:8];
    mag = idx[6] ? tbl[63 - int'(idx[5:0])] : tbl[int'(idx[5:0])];
    return idx[7] ? 9'(-mag) : 9'(mag);
  endfunction

  task automatic model_clear();
    m_acc  = '0;
    for (int i = 0; i < 3; i++) mv[i] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      md[i] = '0;
      mc[i] = '0;
    end
    m_out  = '0;
    mc_out = '0;
  endtask

  // Drive one cycle of inputs, advance the reference at the edge, compare 1ns later.
  task automatic cycle(input logic en, input logic clr, input logic [15:0] fw,
                       input logic [15:0] po);
    logic [15:0] p;
    en_i        = en;
    phase_clr_i = clr;
    freq_word_i = fw;
    phase_off_i = po;
    p = (clr ? 16'h0000 : m_acc) + po;
    @(posedge clk_i);
    if (mv[1]) begin
      m_out  = md[1];
      mc_out = mc[1];
    end
    mv[2] = mv[1];
    md[1] = md[0];
    mc[1] = mc[0];
    mv[1] = mv[0];
    if (en) begin
      md[0] = ref_val(p);
      mc[0] = ref_val(p + 16'h4000);
    end
    mv[0] = en;
    if (clr) m_acc = en ? fw : 16'h0000;
    else if (en) m_acc = m_acc + fw;
    #1;
    n_checks++;
    if (dout_valid_o !== mv[2]) begin
      n_fail++;
      $display("FAIL valid t=%0t: got %b expected %b", $time, dout_valid_o, mv[2]);
    end
    n_checks++;
    if (dout_o !== m_out) begin
      n_fail++;
      $display("FAIL dout t=%0t: got %0d expected %0d", $time, $signed(dout_o), $signed(m_out));
    end
`ifdef SINE_NCO_COS_EN
    n_checks++;
    if (dout_cos_o !== mc_out) begin
      n_fail++;
      $display("FAIL dout_cos t=%0t: got %0d expected %0d", $time, $signed(dout_cos_o), $signed(mc_out));
    end
`endif
  endtask

  task automatic apply_reset();
    rst_ni      = 1'b0;
    en_i        = 1'b0;
    phase_clr_i = 1'b0;
    freq_word_i = '0;
    phase_off_i = '0;
    #1;
    n_checks++;
    if (dout_o !== 9'd0 || dout_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got dout=%0d valid=%b expected 0/0", $signed(dout_o), dout_valid_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'd256, 16'd0);
      n_checks++;
      if (dout_valid_o !== (i == 2)) begin
        n_fail++;
        $display("FAIL first_valid edge %0d: got %b expected %b", i + 1, dout_valid_o, (i == 2));
      end
    end
    n_checks++;
    if (dout_o !== 9'd3) begin
      n_fail++;
      $display("FAIL first_sample: got %0d expected 3", $signed(dout_o));
    end
  endtask

  task automatic test_sweep();
    int s;
    logic [8:0] hand;
    s = 0;
    apply_reset();
    for (int i = 0; i < 262; i++) begin
      cycle(1'b1, 1'b0, 16'd256, 16'd0);
      if (mv[2]) begin
        if (s == 0 || s == 64 || s == 128 || s == 192 || s == 256) begin
          case (s)
            64:      hand = 9'd255;
            128:     hand = 9'h1FD;
            192:     hand = 9'h101;
            default: hand = 9'd3;
          endcase
          n_checks++;
          if (dout_o !== hand) begin
            n_fail++;
            $display("FAIL sweep sample %0d: got %0d expected %0d", s, $signed(dout_o), $signed(hand));
          end
        end
        s++;
      end
    end
  endtask

  task automatic test_static_phase();
    apply_reset();
    repeat (6) cycle(1'b1, 1'b0, 16'd0, 16'h4000);
    n_checks++;
    if (dout_o !== 9'd255) begin
      n_fail++;
      $display("FAIL static_4000: got %0d expected 255", $signed(dout_o));
    end
    repeat (6) cycle(1'b1, 1'b0, 16'd0, 16'hC000);
    n_checks++;
    if (dout_o !== 9'h101) begin
      n_fail++;
      $display("FAIL static_C000: got %0d expected -255", $signed(dout_o));
    end
  endtask

  task automatic test_gating();
    int s;
    s = 0;
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      cycle((i % 2) == 0, 1'b0, 16'd256, 16'd0);
      if (mv[2]) begin
        if (s == 0) begin
          n_checks++;
          if (dout_o !== 9'd3) begin
            n_fail++;
            $display("FAIL gated_first: got %0d expected 3", $signed(dout_o));
          end
        end
        s++;
      end
    end
  endtask

  task automatic test_phase_clr();
    int s;
    s = 0;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(i < 12, i == 10, 16'd256, 16'd0);
      if (mv[2]) begin
        if (s == 10 || s == 11) begin
          n_checks++;
          if (dout_o !== ((s == 10) ? 9'd3 : 9'd9)) begin
            n_fail++;
            $display("FAIL clr sample %0d: got %0d expected %0d", s, $signed(dout_o), (s == 10) ? 3 : 9);
          end
        end
        s++;
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    repeat (20) cycle(1'b1, 1'b0, 16'd256, 16'd0);
    #3;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (dout_o !== 9'd0 || dout_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got dout=%0d valid=%b expected 0/0", $signed(dout_o), dout_valid_o);
    end
    model_clear();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 16'd256, 16'd0);
    n_checks++;
    if (dout_valid_o !== 1'b1 || dout_o !== 9'd3) begin
      n_fail++;
      $display("FAIL restart: got dout=%0d valid=%b expected 3/1", $signed(dout_o), dout_valid_o);
    end
  endtask

`ifdef SINE_NCO_COS_EN
  task automatic test_cos();
    apply_reset();
    repeat (5) cycle(1'b1, 1'b0, 16'd0, 16'd0);
    n_checks++;
    if (dout_o !== 9'd3 || dout_cos_o !== 9'd255) begin
      n_fail++;
      $display("FAIL cos: got sin=%0d cos=%0d expected 3/255", $signed(dout_o), $signed(dout_cos_o));
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 64; k++)
      tbl[k] = $rtoi(255.0 * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / 64.0) + 0.5);
    model_clear();
    test_reset();
    test_sweep();
    test_static_phase();
    test_gating();
    test_phase_clr();
    test_mid_reset();
`ifdef SINE_NCO_COS_EN
    test_cos();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
